// File: rtl/fifo_pkg.sv
// Gray/binary pointer conversions shared by the write- and read-side pointer blocks.
// Callers cast their pointer to 32 bits on the way in and back to pointer width on the way out.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits stay zero, so the low bits decode correctly at any width.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_ff.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module fifo_sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic of the async FIFO: memory write enable/address,
// Gray write pointer for the read domain, and conservative full/almost-full/level/overflow.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_MARGIN = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst,
  input  logic                  i_winc,
  input  logic                  i_wovf_clr,
  input  logic [ADDR_WIDTH:0]   i_rptr_gray,
  output logic                  o_wclken,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [ADDR_WIDTH:0]   o_wptr_gray,
  output logic                  o_wfull,
  output logic                  o_walmost_full,
  output logic [ADDR_WIDTH:0]   o_wlevel,
  output logic                  o_woverflow
);

  import fifo_pkg::*;

  localparam int A     = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AFULL_TH = PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rq, rbin, full_cmp;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic          push;

  fifo_sync_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (i_wclk),
    .rst (i_wrst),
    .d   (i_rptr_gray),
    .q   (rq)
  );

  // Flags are computed from the post-write pointer so full asserts on the accepting edge.
  always_comb begin
    push     = i_winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(push);
    wgray_d  = PW'(bin2gray(32'(wbin_d)));
    rbin     = PW'(gray2bin(32'(rq)));
    full_cmp = {~rq[A:A-1], rq[A-2:0]};
    wfull_d  = (wgray_d == full_cmp);
    level_d  = wbin_d - rbin;
    wafull_d = (level_d >= AFULL_TH);
    // A fresh overflow beats a same-cycle clear.
    wovf_d   = (i_winc & wfull_q) | (wovf_q & ~i_wovf_clr);
  end

  always_ff @(posedge i_wclk or posedge i_wrst) begin
    if (i_wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign o_wclken       = push;
  assign o_waddr        = wbin_q[A-1:0];
  assign o_wptr_gray    = wgray_q;
  assign o_wfull        = wfull_q;
  assign o_walmost_full = wafull_q;
  assign o_wlevel       = level_q;
  assign o_woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: per-cycle expected outputs queued by the driver, compared by a monitor.
module tb_fifo_wptr_full;

  localparam int AW = 3;
  localparam int PW = AW + 1;
  localparam int EW = 1 + AW + PW + 1 + 1 + PW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          winc;
  logic          ovf_clr;
  logic [PW-1:0] rptr_gray;
  logic          o_wclken;
  logic [AW-1:0] o_waddr;
  logic [PW-1:0] o_wptr_gray;
  logic          o_wfull;
  logic          o_walmost_full;
  logic [PW-1:0] o_wlevel;
  logic          o_woverflow;

  always #5 clk = ~clk;

  fifo_wptr_full #(
    .ADDR_WIDTH   (AW),
    .AFULL_MARGIN (1),
    .SYNC_STAGES  (2)
  ) dut (
    .i_wclk         (clk),
    .i_wrst         (rst),
    .i_winc         (winc),
    .i_wovf_clr     (ovf_clr),
    .i_rptr_gray    (rptr_gray),
    .o_wclken       (o_wclken),
    .o_waddr        (o_waddr),
    .o_wptr_gray    (o_wptr_gray),
    .o_wfull        (o_wfull),
    .o_walmost_full (o_walmost_full),
    .o_wlevel       (o_wlevel),
    .o_woverflow    (o_woverflow)
  );

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // Integer reference: write count, read values applied one and two cycles ago, flags.
  int   m_w, m_r0, m_r1;
  logic m_full, m_ovf;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [EW-1:0] act_vec();
    return {o_wclken, o_waddr, o_wptr_gray, o_wfull, o_walmost_full, o_wlevel, o_woverflow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r0 = 0; m_r1 = 0; m_full = 1'b0; m_ovf = 1'b0;
  endtask

  // Called at negedge+1; applies inputs, queues the outputs expected after the next posedge.
  task automatic step(input string name, input logic w, input int rbin, input logic clr);
    int   lvl;
    logic push;
    logic afull;
    winc      = w;
    rptr_gray = to_gray(rbin);
    ovf_clr   = clr;
    push  = w & ~m_full;
    m_ovf = (w & m_full) | (m_ovf & ~clr);
    m_w   = (m_w + int'(push)) % 16;
    lvl   = (m_w - m_r1) & 15;
    m_r1  = m_r0;
    m_r0  = rbin;
    m_full = (lvl == 8);
    afull  = (lvl >= 7);
    exp_q.push_back({w & ~m_full, 3'(m_w % 8), to_gray(m_w), m_full, afull, 4'(lvl), m_ovf});
    name_q.push_back(name);
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_addr"},  32'(o_waddr), 0);
    check({name, "_gray"},  32'(o_wptr_gray), 0);
    check({name, "_full"},  32'(o_wfull), 0);
    check({name, "_afull"}, 32'(o_walmost_full), 0);
    check({name, "_level"}, 32'(o_wlevel), 0);
    check({name, "_ovf"},   32'(o_woverflow), 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string         nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act_vec() !== e) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", nm, act_vec(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; winc = 1'b1; ovf_clr = 1'b0; rptr_gray = '0;
    model_reset();
    #2;
    check_all_zero("t1_rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("t1_rst_held");
    #1;
    rst = 1'b0;
    check("t1_addr_first", 32'(o_waddr), 0);

    // Eight back-to-back writes, read pointer parked at 0
    for (int i = 0; i < 8; i++) begin
      step("t2_write", 1'b1, 0, 1'b0);
      if (i == 6) begin
        check("t2_afull_at7", 32'(o_walmost_full), 1);
        check("t2_notfull_at7", 32'(o_wfull), 0);
      end
    end
    drain();
    check("t2_gray", 32'(o_wptr_gray), 32'hC);
    check("t2_full", 32'(o_wfull), 1);
    check("t2_level", 32'(o_wlevel), 8);

    step("t3_write_full", 1'b1, 0, 1'b0);
    check("t3_wclken", 32'(o_wclken), 0);
    check("t3_addr", 32'(o_waddr), 0);
    check("t3_ovf", 32'(o_woverflow), 1);
    step("t3_ovf_hold", 1'b0, 0, 1'b0);
    check("t3_ovf_sticky", 32'(o_woverflow), 1);
    step("t3_ovf_clr", 1'b0, 0, 1'b1);
    check("t3_ovf_cleared", 32'(o_woverflow), 0);

    // One word read: full must clear exactly on the third edge
    step("t4_rd1", 1'b0, 1, 1'b0);
    check("t4_full_e1", 32'(o_wfull), 1);
    step("t4_rd2", 1'b0, 1, 1'b0);
    check("t4_full_e2", 32'(o_wfull), 1);
    step("t4_rd3", 1'b0, 1, 1'b0);
    check("t4_full_e3", 32'(o_wfull), 0);
    check("t4_level", 32'(o_wlevel), 7);
    check("t4_addr_next", 32'(o_waddr), 0);
    step("t4_write", 1'b1, 1, 1'b0);
    check("t4_refull", 32'(o_wfull), 1);
    winc = 1'b0;

    rst = 1'b1;
    #1;
    check_all_zero("t5_rst");
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    // Sixteen writes with the reader trailing two words behind
    for (int k = 0; k < 16; k++) begin
      step("t5_track", 1'b1, (k >= 2) ? k - 2 : 0, 1'b0);
      if (k == 7) check("t5_msb_set", 32'(o_wptr_gray[PW-1]), 1);
    end
    drain();
    check("t5_gray_wrap", 32'(o_wptr_gray), 0);
    check("t5_msb_clear", 32'(o_wptr_gray[PW-1]), 0);
    check("t5_notfull", 32'(o_wfull), 0);
    winc = 1'b0;

    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("t6_fill", 1'b1, 0, 1'b0);
    end
    check("t6_level5", 32'(o_wlevel), 5);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst_mid");
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("t6_addr_first", 32'(o_waddr), 0);
    check("t6_wclken", 32'(o_wclken), 1);
    step("t6_write1", 1'b1, 0, 1'b0);
    step("t6_write2", 1'b1, 0, 1'b0);
    winc = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
